// File: rtl/sf_tester_pattern_unit_if.sv
// Handshake bundle between the SF tester FSM (master) and the pattern unit (slave).
// Carries pattern load/stop control, generate/read-back data and error statistics.
interface sf_tester_pattern_unit_if #(
   parameter int PARM_CNT_BITS = 26
);
   logic                     i_load;
   logic                     i_mode_chk;
   logic [7:0]               i_pat_start;
   logic [7:0]               i_pat_incr;
   logic                     i_stop;
   logic                     i_gen_ack;
   logic                     i_rd_valid;
   logic [7:0]               i_rd_byte;
   logic                     o_busy;
   logic [7:0]               o_gen_byte;
   logic                     o_chk_valid;
   logic                     o_chk_mismatch;
   logic [PARM_CNT_BITS-1:0] o_byte_cnt;
   logic [PARM_CNT_BITS-1:0] o_err_cnt;
   logic                     o_first_err_seen;
   logic [PARM_CNT_BITS-1:0] o_first_err_idx;

   modport master (
      output i_load, i_mode_chk, i_pat_start, i_pat_incr, i_stop,
             i_gen_ack, i_rd_valid, i_rd_byte,
      input  o_busy, o_gen_byte, o_chk_valid, o_chk_mismatch,
             o_byte_cnt, o_err_cnt, o_first_err_seen, o_first_err_idx
   );

   modport slave (
      input  i_load, i_mode_chk, i_pat_start, i_pat_incr, i_stop,
             i_gen_ack, i_rd_valid, i_rd_byte,
      output o_busy, o_gen_byte, o_chk_valid, o_chk_mismatch,
             o_byte_cnt, o_err_cnt, o_first_err_seen, o_first_err_idx
   );
endinterface

// File: rtl/sf_tester_pattern_unit.sv
// Byte-pattern generator and two-stage read-back checker for the SF tester.
// One running value serves as the program byte in ST_GEN and the expected byte in ST_CHK.
module sf_tester_pattern_unit #(
   parameter int PARM_CNT_BITS = 26
) (
   input  logic                     i_clk_20mhz,
   input  logic                     i_rstn_20mhz,
   sf_tester_pattern_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_CHK  = 2'd2
   } state_t;

   state_t                   state;
   state_t                   state_nxt;

   logic [7:0]               pat_incr;
   logic [7:0]               cur_val;
   logic [PARM_CNT_BITS-1:0] byte_cnt;
   logic [PARM_CNT_BITS-1:0] err_cnt;
   logic                     first_seen;
   logic [PARM_CNT_BITS-1:0] first_idx;
   logic                     busy;

   logic                     s1_valid;
   logic                     s1_mis;
   logic [PARM_CNT_BITS-1:0] s1_idx;
   logic                     chk_valid;
   logic                     chk_mis;

   logic                     gen_adv;
   logic                     chk_adv;

   assign gen_adv = (state == ST_GEN) && bus.i_gen_ack;
   assign chk_adv = (state == ST_CHK) && bus.i_rd_valid;

   always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
      if (!i_rstn_20mhz) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Load has priority over stop so a restart never lands in idle.
   always_comb begin
      state_nxt = state;
      if (bus.i_load) begin
         state_nxt = bus.i_mode_chk ? ST_CHK : ST_GEN;
      end else if (bus.i_stop) begin
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
      if (!i_rstn_20mhz) begin
         busy       <= 1'b0;
         pat_incr   <= 8'h00;
         cur_val    <= 8'h00;
         byte_cnt   <= '0;
         err_cnt    <= '0;
         first_seen <= 1'b0;
         first_idx  <= '0;
         s1_valid   <= 1'b0;
         s1_mis     <= 1'b0;
         s1_idx     <= '0;
         chk_valid  <= 1'b0;
         chk_mis    <= 1'b0;
      end else begin
         busy <= (state_nxt != ST_IDLE);
         if (bus.i_load) begin
            pat_incr   <= bus.i_pat_incr;
            cur_val    <= bus.i_pat_start;
            byte_cnt   <= '0;
            err_cnt    <= '0;
            first_seen <= 1'b0;
            first_idx  <= '0;
            s1_valid   <= 1'b0;
            s1_mis     <= 1'b0;
            chk_valid  <= 1'b0;
            chk_mis    <= 1'b0;
         end else begin
            if (gen_adv || chk_adv) begin
               cur_val <= cur_val + pat_incr;
               if (byte_cnt != '1) begin
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end
            // Stage 1 is not cleared by stop, so an in-flight compare still retires.
            s1_valid  <= chk_adv;
            s1_mis    <= chk_adv && (bus.i_rd_byte != cur_val);
            s1_idx    <= byte_cnt;
            chk_valid <= s1_valid;
            chk_mis   <= s1_valid && s1_mis;
            if (s1_valid && s1_mis) begin
               if (err_cnt != '1) begin
                  err_cnt <= err_cnt + 1'b1;
               end
               if (!first_seen) begin
                  first_seen <= 1'b1;
                  first_idx  <= s1_idx;
               end
            end
         end
      end
   end

   assign bus.o_busy           = busy;
   assign bus.o_gen_byte       = cur_val;
   assign bus.o_chk_valid      = chk_valid;
   assign bus.o_chk_mismatch   = chk_mis;
   assign bus.o_byte_cnt       = byte_cnt;
   assign bus.o_err_cnt        = err_cnt;
   assign bus.o_first_err_seen = first_seen;
   assign bus.o_first_err_idx  = first_idx;

endmodule

// File: tb/tb_sf_tester_pattern_unit.sv
// Directed bench for sf_tester_pattern_unit: generate, check, flush, load/stop priority, reset.
// Expected values are hand-computed pattern sums modulo 256.
module tb_sf_tester_pattern_unit;

   localparam int CNT_BITS = 26;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   sf_tester_pattern_unit_if #(.PARM_CNT_BITS(CNT_BITS)) bus ();

   sf_tester_pattern_unit #(.PARM_CNT_BITS(CNT_BITS)) dut (
      .i_clk_20mhz  (clk),
      .i_rstn_20mhz (rstn),
      .bus          (bus.slave)
   );

   initial clk = 1'b0;
   always #25 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".busy"},      32'(bus.o_busy),           32'h0);
      checkOutput({tag, ".gen_byte"},  32'(bus.o_gen_byte),       32'h0);
      checkOutput({tag, ".chk_valid"}, 32'(bus.o_chk_valid),      32'h0);
      checkOutput({tag, ".chk_mis"},   32'(bus.o_chk_mismatch),   32'h0);
      checkOutput({tag, ".byte_cnt"},  32'(bus.o_byte_cnt),       32'h0);
      checkOutput({tag, ".err_cnt"},   32'(bus.o_err_cnt),        32'h0);
      checkOutput({tag, ".first_seen"},32'(bus.o_first_err_seen), 32'h0);
      checkOutput({tag, ".first_idx"}, 32'(bus.o_first_err_idx),  32'h0);
   endtask

   task automatic applyStimulus(input logic mode_chk, input logic [7:0] start,
                                input logic [7:0] incr, input logic stop);
      bus.i_load      = 1'b1;
      bus.i_mode_chk  = mode_chk;
      bus.i_pat_start = start;
      bus.i_pat_incr  = incr;
      bus.i_stop      = stop;
      tick();
      bus.i_load = 1'b0;
      bus.i_stop = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_val;
      int         pulses;
      int         mis_pulses;
      checks   = 0;
      failures = 0;
      bus.i_load      = 1'b0;
      bus.i_mode_chk  = 1'b0;
      bus.i_pat_start = 8'h00;
      bus.i_pat_incr  = 8'h00;
      bus.i_stop      = 1'b0;
      bus.i_gen_ack   = 1'b0;
      bus.i_rd_valid  = 1'b0;
      bus.i_rd_byte   = 8'h00;
      rstn = 1'b0;
      #60;
      checkResetState("reset");
      tick();
      rstn = 1'b1;
      tick();

      // Generate 0x00 +1, 256 acks back to back
      applyStimulus(1'b0, 8'h00, 8'h01, 1'b0);
      checkOutput("gen1.busy",  32'(bus.o_busy), 32'h1);
      checkOutput("gen1.first", 32'(bus.o_gen_byte), 32'h00);
      bus.i_gen_ack = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tick();
         exp_val = 8'(i + 1);
         checkOutput("gen1.step", 32'(bus.o_gen_byte), 32'(exp_val));
      end
      bus.i_gen_ack = 1'b0;
      checkOutput("gen1.wrap", 32'(bus.o_gen_byte), 32'h00);
      checkOutput("gen1.cnt",  32'(bus.o_byte_cnt), 32'd256);

      // Generate 0x08 +7, 36 acks: 0x08 + 252 = 0x104 -> 0x04
      applyStimulus(1'b0, 8'h08, 8'h07, 1'b0);
      checkOutput("gen2.cnt_clr", 32'(bus.o_byte_cnt), 32'd0);
      checkOutput("gen2.first",   32'(bus.o_gen_byte), 32'h08);
      bus.i_gen_ack = 1'b1;
      for (int i = 0; i < 36; i++) tick();
      bus.i_gen_ack = 1'b0;
      checkOutput("gen2.byte", 32'(bus.o_gen_byte), 32'h04);
      checkOutput("gen2.cnt",  32'(bus.o_byte_cnt), 32'd36);
      bus.i_stop = 1'b1;
      tick();
      bus.i_stop = 1'b0;
      checkOutput("stop.busy", 32'(bus.o_busy),     32'h0);
      checkOutput("stop.byte", 32'(bus.o_gen_byte), 32'h04);
      checkOutput("stop.cnt",  32'(bus.o_byte_cnt), 32'd36);
      bus.i_gen_ack = 1'b1;
      tick();
      tick();
      bus.i_gen_ack = 1'b0;
      checkOutput("idle_ack.byte", 32'(bus.o_gen_byte), 32'h04);
      checkOutput("idle_ack.cnt",  32'(bus.o_byte_cnt), 32'd36);

      // Check 0x10 +0x0F, 256 correct bytes back to back
      applyStimulus(1'b1, 8'h10, 8'h0F, 1'b0);
      checkOutput("chk1.busy", 32'(bus.o_busy), 32'h1);
      pulses     = 0;
      mis_pulses = 0;
      exp_val    = 8'h10;
      for (int i = 0; i < 258; i++) begin
         if (i < 256) begin
            bus.i_rd_valid = 1'b1;
            bus.i_rd_byte  = exp_val;
            exp_val        = exp_val + 8'h0F;
         end else begin
            bus.i_rd_valid = 1'b0;
         end
         tick();
         if (bus.o_chk_valid === 1'b1) pulses++;
         if (bus.o_chk_mismatch === 1'b1) mis_pulses++;
      end
      checkOutput("chk1.pulses",   32'(pulses),     32'd256);
      checkOutput("chk1.mis",      32'(mis_pulses), 32'd0);
      checkOutput("chk1.err_cnt",  32'(bus.o_err_cnt), 32'd0);
      checkOutput("chk1.seen",     32'(bus.o_first_err_seen), 32'h0);
      checkOutput("chk1.byte_cnt", 32'(bus.o_byte_cnt), 32'd256);

      // Check 0x18 +0x17, 12 bytes with corruption at index 5 and 9
      applyStimulus(1'b1, 8'h18, 8'h17, 1'b0);
      exp_val = 8'h18;
      for (int i = 0; i < 14; i++) begin
         if (i < 12) begin
            bus.i_rd_valid = 1'b1;
            bus.i_rd_byte  = (i == 5 || i == 9) ? ~exp_val : exp_val;
            exp_val        = exp_val + 8'h17;
         end else begin
            bus.i_rd_valid = 1'b0;
         end
         tick();
         if (i == 0) checkOutput("chk2.cnt_n1", 32'(bus.o_byte_cnt), 32'd1);
         checkOutput("chk2.valid", 32'(bus.o_chk_valid),
                     32'((i >= 1) && (i <= 12)));
         checkOutput("chk2.mis", 32'(bus.o_chk_mismatch),
                     32'((i == 6) || (i == 10)));
      end
      checkOutput("chk2.err_cnt",   32'(bus.o_err_cnt),        32'd2);
      checkOutput("chk2.seen",      32'(bus.o_first_err_seen), 32'h1);
      checkOutput("chk2.first_idx", 32'(bus.o_first_err_idx),  32'd5);

      // Bad byte then load on the next cycle: compare must be discarded
      applyStimulus(1'b1, 8'h20, 8'h01, 1'b0);
      bus.i_rd_valid = 1'b1;
      bus.i_rd_byte  = 8'h55;
      tick();
      bus.i_rd_valid = 1'b0;
      applyStimulus(1'b1, 8'h30, 8'h01, 1'b0);
      checkOutput("flush.valid",   32'(bus.o_chk_valid), 32'h0);
      checkOutput("flush.err_cnt", 32'(bus.o_err_cnt),   32'd0);
      checkOutput("flush.cnt",     32'(bus.o_byte_cnt),  32'd0);
      tick();
      checkOutput("flush.valid2",  32'(bus.o_chk_valid), 32'h0);
      checkOutput("flush.err2",    32'(bus.o_err_cnt),   32'd0);

      // Load and stop together: load wins, new mode is generate
      applyStimulus(1'b0, 8'h40, 8'h02, 1'b1);
      checkOutput("ldstop.busy", 32'(bus.o_busy),     32'h1);
      checkOutput("ldstop.byte", 32'(bus.o_gen_byte), 32'h40);
      bus.i_gen_ack = 1'b1;
      tick();
      bus.i_gen_ack = 1'b0;
      checkOutput("ldstop.adv", 32'(bus.o_gen_byte), 32'h42);
      checkOutput("ldstop.cnt", 32'(bus.o_byte_cnt), 32'd1);

      // Three errors at indices 1..3, then async reset between edges
      applyStimulus(1'b1, 8'h00, 8'h01, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus.i_rd_valid = 1'b1;
         bus.i_rd_byte  = (i == 0) ? 8'h00 : 8'hF0;
         tick();
      end
      bus.i_rd_valid = 1'b0;
      tick();
      tick();
      checkOutput("pre_rst.err_cnt", 32'(bus.o_err_cnt),       32'd3);
      checkOutput("pre_rst.idx",     32'(bus.o_first_err_idx), 32'd1);
      #5;
      rstn = 1'b0;
      #1;
      checkResetState("async_rst");
      tick();
      rstn = 1'b1;
      tick();
      bus.i_gen_ack  = 1'b1;
      bus.i_rd_valid = 1'b1;
      bus.i_rd_byte  = 8'hAA;
      for (int i = 0; i < 3; i++) tick();
      bus.i_gen_ack  = 1'b0;
      bus.i_rd_valid = 1'b0;
      tick();
      checkResetState("idle_inputs");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sf_tester_pattern_unit.md
# sf_tester_pattern_unit

Byte-pattern generator and read-back checker that sits directly downstream of the SF tester FSM. The FSM selects one of its four start/increment pattern pairs and loads it here. During page-program commands this block supplies the next byte to write. During read commands it compares each returned byte against the regenerated expected value and accumulates error statistics, which the FSM shows in its final display state.

## Interface
- PARM_CNT_BITS, 26, width of byte-index and error counters (covers the 256 Mbit flash byte count).
- i_clk_20mhz  in  1  system clock; all logic on the rising edge.
- i_rstn_20mhz  in  1  reset, asynchronous assert, active-low.
- i_load  in  1  one-cycle pulse: latch pattern and mode, clear statistics, start the run.
- i_mode_chk  in  1  sampled with i_load: 0 = generate, 1 = check.
- i_pat_start  in  8  pattern start value, sampled with i_load.
- i_pat_incr  in  8  pattern increment, sampled with i_load.
- i_stop  in  1  one-cycle pulse: end the run and return to idle.
- i_gen_ack  in  1  consumer took o_gen_byte; advance the pattern.
- i_rd_valid  in  1  i_rd_byte is valid this cycle.
- i_rd_byte  in  8  byte read back from flash.
- o_busy  out  1  high in ST_GEN or ST_CHK.
- o_gen_byte  out  8  current pattern byte to program.
- o_chk_valid  out  1  one-cycle pulse: a compare result is presented.
- o_chk_mismatch  out  1  qualified by o_chk_valid; 1 = byte differed.
- o_byte_cnt  out  PARM_CNT_BITS  bytes generated or checked since load.
- o_err_cnt  out  PARM_CNT_BITS  mismatches since load.
- o_first_err_seen  out  1  at least one mismatch since load.
- o_first_err_idx  out  PARM_CNT_BITS  byte index of the first mismatch.

## Operation
- States: ST_IDLE, ST_GEN, ST_CHK. Reset enters ST_IDLE.
- i_load is accepted in any state:
  - latches start and increment;
  - sets the expected/generate value to i_pat_start;
  - clears o_byte_cnt, o_err_cnt, o_first_err_seen and o_first_err_idx;
  - flushes the compare pipeline;
  - enters ST_GEN if i_mode_chk=0, otherwise ST_CHK.
- i_stop moves to ST_IDLE. Statistics and o_gen_byte hold until the next i_load.
- i_load together with i_stop in the same cycle: i_load wins.
- ST_GEN:
  - o_gen_byte shows the current value;
  - on each i_gen_ack the value becomes value + incr (mod 256) and o_byte_cnt increments.
- ST_CHK:
  - on each i_rd_valid, stage 1 registers the compare (i_rd_byte != expected) and the current o_byte_cnt as the index;
  - in the same cycle, expected advances by incr (mod 256) and o_byte_cnt increments.
- Stage 2 (next cycle):
  - pulses o_chk_valid with o_chk_mismatch;
  - on a mismatch, o_err_cnt increments;
  - on the first mismatch, o_first_err_seen is set and o_first_err_idx takes the stage-1 index.
- i_gen_ack outside ST_GEN and i_rd_valid outside ST_CHK are ignored and change no state.
- A compare already in stage 1 when i_stop arrives still completes in stage 2.
- A compare in stage 1 when i_load arrives is discarded: no o_chk_valid, no count change.
- o_byte_cnt and o_err_cnt saturate at all-ones; they never wrap.
- The pattern value wraps modulo 256.
- Increment 0x00 is legal and yields a constant pattern.

## Timing
- Reset values:
  - o_busy=0, o_gen_byte=0x00, o_chk_valid=0, o_chk_mismatch=0;
  - o_byte_cnt=0, o_err_cnt=0, o_first_err_seen=0, o_first_err_idx=0;
  - internal start, increment and expected registers = 0.
- All outputs are registered.
- i_load at cycle N: o_busy=1 and o_gen_byte=i_pat_start at N+1.
- i_gen_ack at cycle N: o_gen_byte and o_byte_cnt update at N+1. Back-to-back acks every cycle are supported.
- i_rd_valid at cycle N: o_chk_valid/o_chk_mismatch at N+2; o_err_cnt and first-error fields update at N+2; o_byte_cnt at N+1.
- Full throughput: one checked byte per cycle.
- i_stop at cycle N: o_busy=0 at N+1.
- Asynchronous reset mid-run returns all outputs to reset values immediately. Pipeline contents are lost.

## Test plan
- Reset, then load gen start=0x00 incr=0x01, ack 256 times -> o_gen_byte steps 0x00..0xFF and returns to 0x00; o_byte_cnt=256.
- Load gen start=0x08 incr=0x07, 36 acks -> o_gen_byte=0x04, o_byte_cnt=36. i_stop -> o_busy=0, values held.
- Load chk start=0x10 incr=0x0F, feed 256 correct bytes back-to-back -> 256 o_chk_valid pulses, all mismatch=0, o_err_cnt=0, o_first_err_seen=0.
- Load chk start=0x18 incr=0x17, corrupt bytes at index 5 and 9 -> o_err_cnt=2, o_first_err_idx=5, mismatch pulses 2 cycles after each bad byte.
- i_rd_valid with a bad byte, then i_load the next cycle -> no o_chk_valid, o_err_cnt=0. i_load and i_stop in the same cycle -> busy in the new mode.
- Assert i_rstn_20mhz low mid-check with o_err_cnt=3 -> all outputs return to reset values before the next clock edge; i_gen_ack and i_rd_valid in ST_IDLE have no effect.
